aes_response_checker: RTL

- Downstream consumer of the target's serial output in the glitch rig. The power/glitch controller drives the ATmega328 supply; the target then emits its AES-128 ciphertext over UART.
- This block performs the following steps:
  - receives that ciphertext on a pin;
  - assembles 16 bytes;
  - compares the result against the known-good ciphertext;
  - reports MATCH, FAULT, TIMEOUT or FRAME_ERR back to the controller.
- Target: ice40hx1k, go-board.

---
 rtl/aes_response_checker.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/aes_response_checker.sv
// rtl/aes_response_checker.sv - UART ciphertext capture and golden-compare for the glitch rig
module aes_response_checker #(
    parameter int            CLK_HZ         = 25000000,
    parameter int            BAUD           = 115200,
    parameter int            BLOCK_BYTES    = 16,
    parameter int            TIMEOUT_CYCLES = 2500000,
    parameter logic [127:0]  GOLDEN         = 128'h69c4e0d86a7b0430d8cdb78070b4c55a
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         RX,
    input  logic         ARM,
    output logic         BUSY,
    output logic         DONE,
    output logic [1:0]   RESULT,
    output logic [127:0] CT,
    output logic [4:0]   BYTE_CNT
);

    localparam int BIT_CYCLES = CLK_HZ / BAUD;
    localparam int CW         = $clog2(BIT_CYCLES + 1);
    localparam int TW         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [4:0]    BLOCK_LAST = 5'(BLOCK_BYTES - 1);

    localparam logic [1:0] RES_MATCH     = 2'b00;
    localparam logic [1:0] RES_FAULT     = 2'b01;
    localparam logic [1:0] RES_TIMEOUT   = 2'b10;
    localparam logic [1:0] RES_FRAME_ERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LISTEN,
        CHECK
    } state_t;

    // RX synchronizer; both stages idle high so reset never looks like a start bit
    logic sync1_q;
    logic rxs_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= RX;
            rxs_q   <= sync1_q;
        end
    end

    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            byte_valid;
    logic            frame_err;

    // UART receiver register stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // UART receiver: half-bit to centre on the start bit, then whole-bit sampling
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (!rxs_q) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rxs_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (rxs_q) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                rx_state_d = R_IDLE;
            end
        endcase
    end

    state_t          state_q, state_d;
    logic [127:0]    ct_q, ct_d;
    logic [4:0]      byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      result_q, result_d;
    logic            done_q, done_d;
    logic [127:0]    ct_shifted;

    assign ct_shifted = {ct_q[119:0], rx_shift_q};

    // Capture FSM register stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            ct_q       <= '0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ct_q       <= ct_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    // Capture FSM: ARM always restarts; the verdict is registered so it lines up with CHECK
    always_comb begin
        state_d    = state_q;
        ct_d       = ct_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        result_d   = result_q;
        done_d     = 1'b0;
        if (ARM) begin
            state_d    = LISTEN;
            ct_d       = '0;
            byte_cnt_d = '0;
            tmo_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                LISTEN: begin
                    if (frame_err) begin
                        result_d = RES_FRAME_ERR;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else if (byte_valid) begin
                        ct_d       = ct_shifted;
                        byte_cnt_d = byte_cnt_q + 5'd1;
                        tmo_d      = '0;
                        if (byte_cnt_q == BLOCK_LAST) begin
                            result_d = (ct_shifted == GOLDEN) ? RES_MATCH : RES_FAULT;
                            done_d   = 1'b1;
                            state_d  = CHECK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        tmo_d    = tmo_q + TW'(1);
                        result_d = RES_TIMEOUT;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign BUSY     = (state_q == LISTEN);
    assign DONE     = done_q;
    assign RESULT   = result_q;
    assign CT       = ct_q;
    assign BYTE_CNT = byte_cnt_q;

endmodule
